core_sequencer: RTL and testbench

//  Multi-cycle control FSM for the TinyRisc-V core. Sequences one instruction at a time:

---
 rtl/core_sequencer.sv | 171 +++++++++++++++++
 tb/tb_core_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB/HALT sequencer for the TinyRisc-V core.
// Optional performance counters are enabled with `define SEQ_PERF_CNT_EN.
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] ir,
    output logic [XLEN-1:0] pc,
    input  logic [6:0]      opcode,
    input  logic            wb_reg,
    input  logic            br_taken,
    input  logic [XLEN-1:0] pc_target,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            rf_we,
    output logic            rf_wsel,
    output logic            halted
`ifdef SEQ_PERF_CNT_EN
   ,output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instret_cnt
`endif
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic            imem_req_q, dmem_req_q, dmem_we_q;
    logic            rf_we_q, rf_wsel_q, halted_q;

    logic is_load_s, is_store_s, is_alu_s, take_tgt_s;

    assign is_load_s  = (opcode == OPC_LOAD);
    assign is_store_s = (opcode == OPC_STORE);
    assign is_alu_s   = (opcode == OPC_OP)     || (opcode == OPC_OPIMM) ||
                        (opcode == OPC_BRANCH) || (opcode == OPC_LUI)   ||
                        (opcode == OPC_AUIPC)  || (opcode == OPC_JAL)   ||
                        (opcode == OPC_JALR);
    assign take_tgt_s = (opcode == OPC_JAL) || (opcode == OPC_JALR) ||
                        ((opcode == OPC_BRANCH) && br_taken);

    // Next-state, next-PC and instruction-latch logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                if (is_load_s || is_store_s) begin
                    state_d = S_MEM;
                end else if (is_alu_s) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                if (take_tgt_s) begin
                    pc_d = pc_target;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // State, PC, IR and output registers; outputs decode the upcoming state so they are glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= NOP_INSN;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_wsel_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            imem_req_q <= (state_d == S_FETCH);
            dmem_req_q <= (state_d == S_MEM);
            dmem_we_q  <= (state_d == S_MEM) && is_store_s;
            rf_we_q    <= (state_d == S_WB) && wb_reg && !is_store_s;
            rf_wsel_q  <= (state_d == S_WB) && is_load_s;
            halted_q   <= (state_d == S_HALT);
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign pc        = pc_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign rf_we     = rf_we_q;
    assign rf_wsel   = rf_wsel_q;
    assign halted    = halted_q;

`ifdef SEQ_PERF_CNT_EN
    logic [XLEN-1:0] cycle_cnt_q, instret_cnt_q;

    // Cycle counter freezes once halted; retire counter counts WB cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= 32'd0;
            instret_cnt_q <= 32'd0;
        end else begin
            if (state_q != S_HALT) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end else begin
                cycle_cnt_q <= cycle_cnt_q;
            end
            if (state_q == S_WB) begin
                instret_cnt_q <= instret_cnt_q + 32'd1;
            end else begin
                instret_cnt_q <= instret_cnt_q;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized self-checking bench for core_sequencer with an instruction-level reference model.
module tb_core_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [6:0]  O_LOAD = 7'b0000011, O_STORE = 7'b0100011, O_OP = 7'b0110011,
                            O_OPIMM = 7'b0010011, O_BR = 7'b1100011, O_LUI = 7'b0110111,
                            O_AUIPC = 7'b0010111, O_JAL = 7'b1101111, O_JALR = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'd0;
    logic [31:0] ir, pc;
    logic [6:0]  opcode;
    logic        wb_reg = 1'b0, br_taken = 1'b0;
    logic [31:0] pc_target = 32'd0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic        rf_we, rf_wsel, halted;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_pc;
    logic [6:0]  legal_ops [9];

    always #5 clk = ~clk;

    // decode_execute stand-in: opcode is the low 7 bits of IR
    assign opcode = ir[6:0];

    core_sequencer #(.RESET_PC(RST_PC), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .pc(pc), .opcode(opcode), .wb_reg(wb_reg), .br_taken(br_taken),
        .pc_target(pc_target), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .halted(halted)
`ifdef SEQ_PERF_CNT_EN
       ,.cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    // Drives one instruction from a FETCH negedge until the next FETCH (or halt) and records what was seen.
    task automatic run_instr(input logic [31:0] instr, input int iwait, input int dwait,
                             input logic wbr, input logic brt, input logic [31:0] tgt,
                             output int cycles, output int we_cnt, output int we_cyc,
                             output logic wsel_at_we, output int dreq_cnt, output logic dwe_seen,
                             output logic halt_seen, output logic timeout);
        int   ireq;
        logic fetched;
        cycles = 0; we_cnt = 0; we_cyc = -1; wsel_at_we = 1'b0; dreq_cnt = 0;
        dwe_seen = 1'b0; halt_seen = 1'b0; timeout = 1'b1; ireq = 0; fetched = 1'b0;
        wb_reg = wbr; br_taken = brt; pc_target = tgt; imem_rdata = instr;
        for (int c = 0; c < 64; c++) begin
            if (halted) begin halt_seen = 1'b1; timeout = 1'b0; break; end
            if (imem_req && fetched) begin timeout = 1'b0; break; end
            if (imem_req) begin
                ireq++;
                imem_ack = (ireq == iwait + 1);
                if (imem_ack) fetched = 1'b1;
            end else begin
                imem_ack = 1'($urandom_range(0, 1));
            end
            if (dmem_req) begin
                dreq_cnt++;
                dmem_ack = (dreq_cnt == dwait + 1);
                if (dmem_we) dwe_seen = 1'b1;
            end else begin
                dmem_ack = 1'($urandom_range(0, 1));
            end
            if (rf_we) begin we_cnt++; we_cyc = cycles; wsel_at_we = rf_wsel; end
            @(posedge clk); @(negedge clk);
            cycles++;
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    // Executes one legal instruction and checks it against the instruction-level model.
    task automatic test_instr(input string name, input logic [31:0] instr, input int iwait,
                              input int dwait, input logic wbr, input logic brt,
                              input logic [31:0] tgt);
        logic [6:0]  op;
        logic        ld, st, jmp, wsel, dwe, hs, to;
        int          exp_cyc, exp_dreq, exp_we, cyc, wec, wecyc, dreq;
        logic [31:0] exp_pc;
        op  = instr[6:0];
        ld  = (op == O_LOAD);
        st  = (op == O_STORE);
        jmp = (op == O_JAL) || (op == O_JALR) || ((op == O_BR) && brt);
        exp_dreq = (ld || st) ? dwait + 1 : 0;
        exp_cyc  = (iwait + 1) + 1 + exp_dreq + 1;
        exp_we   = (wbr && !st) ? 1 : 0;
        exp_pc   = jmp ? tgt : model_pc + 32'd4;
        run_instr(instr, iwait, dwait, wbr, brt, tgt, cyc, wec, wecyc, wsel, dreq, dwe, hs, to);
        checks++;
        if (to || hs) begin errors++; $display("FAIL %s end: timeout=%0b halted=%0b, required 0/0", name, to, hs); end
        checks++;
        if (cyc != exp_cyc) begin errors++; $display("FAIL %s cycles: got %0d expected %0d", name, cyc, exp_cyc); end
        checks++;
        if (wec != exp_we) begin errors++; $display("FAIL %s rf_we pulses: got %0d expected %0d", name, wec, exp_we); end
        if (exp_we == 1) begin
            checks++;
            if (wecyc != exp_cyc - 1) begin errors++; $display("FAIL %s rf_we cycle: got %0d expected %0d", name, wecyc, exp_cyc - 1); end
            checks++;
            if (wsel !== ld) begin errors++; $display("FAIL %s rf_wsel: got %0b expected %0b", name, wsel, ld); end
        end
        checks++;
        if (dreq != exp_dreq) begin errors++; $display("FAIL %s dmem_req cycles: got %0d expected %0d", name, dreq, exp_dreq); end
        checks++;
        if (dwe !== st) begin errors++; $display("FAIL %s dmem_we: got %0b expected %0b", name, dwe, st); end
        checks++;
        if (ir !== instr) begin errors++; $display("FAIL %s ir: got %h expected %h", name, ir, instr); end
        checks++;
        if (pc !== exp_pc || imem_addr !== exp_pc) begin
            errors++; $display("FAIL %s pc: got pc=%h addr=%h expected %h", name, pc, imem_addr, exp_pc);
        end
        model_pc = exp_pc;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (pc !== RST_PC || ir !== NOP) begin errors++; $display("FAIL reset_pc_ir: got pc=%h ir=%h expected %h %h", pc, ir, RST_PC, NOP); end
        checks++;
        if ({imem_req, dmem_req, dmem_we, rf_we, rf_wsel, halted} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 000000", {imem_req, dmem_req, dmem_we, rf_we, rf_wsel, halted});
        end
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++; $display("FAIL reset_release: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, RST_PC);
        end
        model_pc = RST_PC;
    endtask

    task automatic test_alu();
        test_instr("add", 32'h0020_81B3, 0, 0, 1'b1, 1'b0, 32'h0000_0BAD);
    endtask

    task automatic test_load();
        test_instr("lw", 32'h0000_A283, 2, 1, 1'b1, 1'b0, 32'h0000_0000);
    endtask

    task automatic test_branch();
        test_instr("jal_a", 32'h0000_006F, 0, 0, 1'b1, 1'b0, 32'h0000_0100);
        test_instr("bne_taken", 32'h0020_9A63, 0, 0, 1'b0, 1'b1, 32'h0000_0114);
        test_instr("jal_b", 32'h0000_006F, 1, 0, 1'b1, 1'b0, 32'h0000_0100);
        test_instr("bne_not", 32'h0020_9A63, 0, 0, 1'b0, 1'b0, 32'h0000_0114);
        test_instr("sw", 32'h0020_A023, 0, 2, 1'b1, 1'b0, 32'h0000_0000);
    endtask

    task automatic test_halt();
        int   cyc, wec, wecyc, dreq;
        logic wsel, dwe, hs, to;
        run_instr(32'h0000_0000, 1, 0, 1'b1, 1'b0, 32'h0000_0040, cyc, wec, wecyc, wsel, dreq, dwe, hs, to);
        checks++;
        if (!hs || cyc != 3) begin errors++; $display("FAIL halt_entry: got halted=%0b cycles=%0d expected 1 3", hs, cyc); end
        for (int i = 0; i < 6; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            @(posedge clk); @(negedge clk);
            checks++;
            if (imem_req || dmem_req || rf_we || !halted || pc !== model_pc || ir !== 32'h0) begin
                errors++; $display("FAIL halt_frozen: got req=%b dreq=%b we=%b halted=%b pc=%h expected 0 0 0 1 %h", imem_req, dmem_req, rf_we, halted, pc, model_pc);
            end
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (halted || !imem_req || pc !== RST_PC) begin
            errors++; $display("FAIL halt_recover: got halted=%b req=%b pc=%h expected 0 1 %h", halted, imem_req, pc, RST_PC);
        end
        model_pc = RST_PC;
    endtask

    task automatic test_abort();
        test_instr("add_pre", 32'h0020_81B3, 0, 0, 1'b1, 1'b0, 32'h0);
        imem_rdata = 32'h0020_A023; wb_reg = 1'b1; imem_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        imem_ack = 1'b0; dmem_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL abort_mem: got req=%b we=%b expected 1 1", dmem_req, dmem_we); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_req || rf_we || imem_req || pc !== RST_PC || ir !== NOP) begin
            errors++; $display("FAIL abort_reset: got dreq=%b we=%b ireq=%b pc=%h ir=%h expected 0 0 0 %h %h", dmem_req, rf_we, imem_req, pc, ir, RST_PC, NOP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin errors++; $display("FAIL abort_release: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, RST_PC); end
        model_pc = RST_PC;
    endtask

    task automatic test_wrap();
        test_instr("jal_top", 32'h0000_006F, 0, 0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        test_instr("add_wrap", 32'h0020_81B3, 0, 0, 1'b1, 1'b0, 32'h0000_0040);
        checks++;
        if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h expected 00000000", pc); end
    endtask

    task automatic test_random();
        logic [31:0] r, t;
`ifdef SEQ_PERF_CNT_EN
        logic [31:0] ret0;
        ret0 = instret_cnt;
`endif
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            t = $urandom;
            t[1:0] = 2'b00;
            test_instr("rand", {r[31:7], legal_ops[$urandom_range(0, 8)]}, $urandom_range(0, 3),
                       $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
        end
`ifdef SEQ_PERF_CNT_EN
        checks++;
        if (instret_cnt - ret0 !== 32'd40) begin errors++; $display("FAIL instret: got %0d expected 40", instret_cnt - ret0); end
`endif
    endtask

    initial begin
        legal_ops = '{O_LOAD, O_STORE, O_OP, O_OPIMM, O_BR, O_LUI, O_AUIPC, O_JAL, O_JALR};
        model_pc = RST_PC;
        test_reset();
        test_alu();
        test_load();
        test_branch();
        test_halt();
        test_abort();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
